// File: rtl/rx_timing_gen.sv
// rx_timing_gen: oversampled RX edge/bit timing with mid-bit sample strobes and an end-of-frame pulse.
// Latency: Done is combinational; sample_stb/sample_idx/frame_done are registered, one cycle after the qualifying count.
// No backpressure: counting is gated only by Edge_EN_CNT/Bit_EN_CNT. Macro RX_TIMING_SAMPLE3_EN adds strobes at M-1 and M+1.
module rx_timing_gen #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Edge_EN_CNT,
  input  logic                  Bit_EN_CNT,
  input  logic [PRESCALE_W-1:0] prescaler,
  input  logic [BIT_CNT_W-1:0]  frame_len,
  output logic [PRESCALE_W-1:0] Edge_Counter,
  output logic [BIT_CNT_W-1:0]  Bit_Counter,
  output logic                  Done,
  output logic                  sample_stb,
  output logic [1:0]            sample_idx,
  output logic                  frame_done,
  output logic                  cfg_err
);

  // IDLE: waiting for a run to start (next high Edge_EN_CNT is a capture edge).
  // RUN: counting with a valid latched prescaler. ERR: latched prescaler too small.
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ERR} state_t;

  state_t                state, state_nxt;
  logic [PRESCALE_W-1:0] p_reg, p_last, mid;
  logic [BIT_CNT_W-1:0]  l_reg, l_last;
  logic                  capture, cap_bad, counting, hit;
  logic [1:0]            hit_idx;

  assign cfg_err = (state == ST_ERR);

  // Run-state register; reset lands in IDLE so the first enabled edge after reset captures.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state, run qualifiers, Done and sample-point decode.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    cap_bad   = 1'b0;
    counting  = 1'b0;
    hit       = 1'b0;
    hit_idx   = 2'd1;
    p_last    = p_reg - PRESCALE_W'(1);
    mid       = p_reg >> 1;
    // A zero frame length behaves as a one-bit frame.
    l_last    = (l_reg == '0) ? '0 : l_reg - BIT_CNT_W'(1);
    case (state)
      ST_IDLE: begin
        if (Edge_EN_CNT) begin
          capture   = 1'b1;
          cap_bad   = (prescaler < PRESCALE_W'(4));
          state_nxt = cap_bad ? ST_ERR : ST_RUN;
        end
      end
      ST_RUN: begin
        if (!Edge_EN_CNT) state_nxt = ST_IDLE;
        else              counting  = 1'b1;
      end
      ST_ERR: begin
        if (!Edge_EN_CNT) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    Done = counting && (Edge_Counter == p_last);
`ifdef RX_TIMING_SAMPLE3_EN
    if (Edge_Counter == mid - PRESCALE_W'(1)) begin
      hit     = 1'b1;
      hit_idx = 2'd0;
    end else if (Edge_Counter == mid) begin
      hit     = 1'b1;
      hit_idx = 2'd1;
    end else if (Edge_Counter == mid + PRESCALE_W'(1)) begin
      hit     = 1'b1;
      hit_idx = 2'd2;
    end
`else
    hit     = (Edge_Counter == mid);
    hit_idx = 2'd1;
`endif
  end

  // Latch the run configuration on the capture edge; later input changes are ignored.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_reg <= '0;
      l_reg <= '0;
    end else if (capture) begin
      p_reg <= prescaler;
      l_reg <= frame_len;
    end
  end

  // Edge counter: the capture cycle is count 0, so a good capture moves straight to 1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                     Edge_Counter <= '0;
    else if (capture && !cap_bad) Edge_Counter <= PRESCALE_W'(1);
    else if (counting)            Edge_Counter <= (Edge_Counter >= p_last) ? '0 : Edge_Counter + PRESCALE_W'(1);
    else                          Edge_Counter <= '0;
  end

  // Bit counter: clear has priority; advances on the last edge of each bit and wraps at L-1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                          Bit_Counter <= '0;
    else if (!Bit_EN_CNT || cap_bad || state == ST_ERR) Bit_Counter <= '0;
    else if (Done)                                     Bit_Counter <= (Bit_Counter >= l_last) ? '0 : Bit_Counter + BIT_CNT_W'(1);
  end

  // Registered strobes: sample point hit and end of the last bit of the frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sample_stb <= 1'b0;
      sample_idx <= 2'd0;
      frame_done <= 1'b0;
    end else begin
      sample_stb <= counting && hit;
      if (counting && hit) sample_idx <= hit_idx;
      frame_done <= Done && Bit_EN_CNT && (Bit_Counter == l_last);
    end
  end

endmodule
